fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core. It sits directly upstream of the instruction memory and feeds the decoder.
- Holds the program counter and drives the word address into the instruction memory. It registers the returned instruction into the IF/ID pipeline register, together with its PC and PC+4.
- Handles pipeline stall, control-flow redirect (branch/jal/jalr), and fetch past the end of instruction memory.

Parameters:
- RESET_PC, 16'h0000, byte address loaded into PC on reset.
- IMEM_WORDS, 32, number of valid 32-bit words in instruction memory; word addresses >= IMEM_WORDS are out of range.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID when the slot is invalid.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard stall from decode; freezes PC and IF/ID.
- redirect_i  in  1  taken branch/jump from execute.
- redirect_target_i  in  16  byte target address for the redirect.
- imem_addr_o  out  16  word index into instruction memory, = pc >> 2 (combinational).
- imem_instr_i  in  32  instruction word from memory; combinational read, valid in the same cycle.
- pc_o  out  16  current fetch PC (byte address).
- ifid_instr_o  out  32  registered instruction to decode.
- ifid_pc_o  out  16  byte PC of ifid_instr_o.
- ifid_pc4_o  out  16  ifid_pc_o + 4, mod 2^16.
- ifid_valid_o  out  1  IF/ID slot holds a real instruction.
- fetch_fault_o  out  1  sticky; fetch attempted out of range.

Behaviour:
- Reset (synchronous, highest priority): on the clock edge with reset=1:
  - pc <= RESET_PC & 16'hFFFC
  - ifid_instr_o <= NOP_INSTR, ifid_pc_o <= 0, ifid_pc4_o <= 0
  - ifid_valid_o <= 0, fetch_fault_o <= 0
- Reset overrides stall, redirect and fault in the same cycle. Reset mid-stall or mid-fault returns to the reset state.
- imem_addr_o = {2'b00, pc[15:2]}, combinational from the pc register.
- Define oob = (pc[15:2] >= IMEM_WORDS).
- Per-edge priority when reset=0 (first match wins):
  1. fetch_fault_o=1 (halted): pc holds; ifid_instr_o <= NOP_INSTR, ifid_valid_o <= 0. stall_i and redirect_i are ignored. Only reset exits this state.
  2. redirect_i=1:
     - pc <= redirect_target_i & 16'hFFFC (bits[1:0] silently cleared).
     - IF/ID squashed: ifid_instr_o <= NOP_INSTR, ifid_valid_o <= 0; ifid_pc_o and ifid_pc4_o hold.
     - Redirect beats stall in the same cycle.
  3. stall_i=1: pc, all ifid_* outputs and fetch_fault_o hold. imem_addr_o keeps presenting the same address.
  4. oob=1:
     - fetch_fault_o <= 1, pc holds.
     - ifid_instr_o <= NOP_INSTR, ifid_valid_o <= 0.
  5. Normal advance:
     - ifid_instr_o <= imem_instr_i, ifid_pc_o <= pc, ifid_pc4_o <= pc+4, ifid_valid_o <= 1.
     - pc <= pc+4 (16-bit wrap).
- Latency:
  - An instruction at PC p appears on ifid_* one edge after pc=p, unless stalled.
  - Throughput is 1 instruction/cycle with no stall or redirect.
  - A redirect costs exactly one bubble: the target is fetched in the cycle after the redirect and reaches IF/ID on the following edge.
- Checks:
  - pc[1:0] is always 0.
  - ifid_pc4_o == ifid_pc_o + 4 whenever ifid_valid_o=1.
  - pc_o mirrors the pc register.
- Out-of-range fetch: the IM output for an out-of-range address is never registered as valid.

Test Plan:
- Reset: hold reset 2 cycles with RESET_PC=0.
  -> pc_o=0x0000, imem_addr_o=0, ifid_valid_o=0, ifid_instr_o=0x00000013, fetch_fault_o=0.
- Sequential fetch: memory word k = 0xA0000000+k, release reset, run 3 edges.
  -> ifid_instr_o=0xA0000002, ifid_pc_o=0x0008, ifid_pc4_o=0x000C, pc_o=0x000C, ifid_valid_o=1.
- Stall: stall_i=1 for 2 cycles at pc=0x0008.
  -> all outputs frozen (ifid_pc_o=0x0004, pc_o=0x0008).
  -> after release, next edge gives ifid_instr_o=0xA0000002.
- Redirect with misaligned target: redirect_i=1, target=0x002B, with stall_i=1 in the same cycle.
  -> pc_o=0x0028, ifid_valid_o=0.
  -> next edge: ifid_instr_o=0xA000000A, ifid_pc_o=0x0028.
- Out-of-range: redirect to 0x007C (word 31), IMEM_WORDS=32.
  -> word 31 is registered valid, pc becomes 0x0080.
  -> next edge: fetch_fault_o=1, ifid_valid_o=0, pc_o stays 0x0080.
  -> a following redirect_i=1 to 0x0000 is ignored.
- Recovery: assert reset while fetch_fault_o=1.
  -> fetch_fault_o=0, pc_o=0x0000.
  -> fetching resumes with ifid_instr_o=0xA0000000 one edge after reset is released.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr_o  [15:0]  word index driven by the fetch stage (pc >> 2)
//   imem_instr_i [31:0]  instruction word returned combinationally by memory
// Modports:
//   master : fetch side (drives the address, receives the instruction)
//   slave  : memory side (receives the address, returns the instruction)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   logic [15:0] imem_addr_o;
   logic [31:0] imem_instr_i;

   modport master (output imem_addr_o, input imem_instr_i);
   modport slave  (input imem_addr_o, output imem_instr_i);
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into the IF/ID pipeline register along with its
// PC and PC+4. Handles decode stalls, execute redirects and a sticky halt when
// fetch runs past the end of instruction memory.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   stall_i              freeze PC and IF/ID
//   redirect_i           taken branch/jump; loads redirect_target_i into PC
//   redirect_target_i    byte target (low two bits ignored)
//   imem                 instruction-memory bus (master side)
//   pc_o                 current fetch PC (byte address)
//   ifid_instr_o         instruction handed to decode
//   ifid_pc_o            byte PC of ifid_instr_o
//   ifid_pc4_o           ifid_pc_o + 4
//   ifid_valid_o         IF/ID slot holds a real instruction
//   fetch_fault_o        sticky out-of-range fetch indication
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int unsigned IMEM_WORDS = 32,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [15:0]         redirect_target_i,
   fetch_stage_if.master       imem,
   output logic [15:0]         pc_o,
   output logic [31:0]         ifid_instr_o,
   output logic [15:0]         ifid_pc_o,
   output logic [15:0]         ifid_pc4_o,
   output logic                ifid_valid_o,
   output logic                fetch_fault_o
);

   localparam int unsigned PC_W    = 16;
   localparam int unsigned INSTR_W = 32;
   localparam logic [PC_W-1:0] ALIGN_MASK = 16'hFFFC;
   localparam logic [PC_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
   localparam logic [PC_W-1:0] PC_STEP    = 16'd4;

   logic [PC_W-1:0]    pc_q,    pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    ipc_q,   ipc_d;
   logic [PC_W-1:0]    ipc4_q,  ipc4_d;
   logic               valid_q, valid_d;
   logic               fault_q, fault_d;
   logic               oob_c;

   // Word address straight from the PC register; memory reads combinationally.
   assign imem.imem_addr_o = {2'b00, pc_q[PC_W-1:2]};

   // Fetch address beyond the populated memory.
   assign oob_c = (32'(pc_q[PC_W-1:2]) >= IMEM_WORDS);

   // Next-state: halt > redirect > stall > out-of-range > advance.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      valid_d = valid_q;
      fault_d = fault_q;

      if (fault_q) begin
         // Halted: keep emitting bubbles until reset.
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (redirect_i) begin
         // Squash the wrong-path slot; its PC fields are left as they were.
         pc_d    = redirect_target_i & ALIGN_MASK;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (stall_i) begin
         // Everything holds.
      end else if (oob_c) begin
         // Never register the memory's out-of-range output as valid.
         fault_d = 1'b1;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else begin
         instr_d = imem.imem_instr_i;
         ipc_d   = pc_q;
         ipc4_d  = pc_q + PC_STEP;
         valid_d = 1'b1;
         pc_d    = pc_q + PC_STEP;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= PC_RST;
         instr_q <= NOP_INSTR;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign pc_o          = pc_q;
   assign ifid_instr_o  = instr_q;
   assign ifid_pc_o     = ipc_q;
   assign ifid_pc4_o    = ipc4_q;
   assign ifid_valid_o  = valid_q;
   assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage: a behavioural model predicts the outputs
// after each edge, the prediction is queued when stimulus is driven and popped
// and compared once the edge has happened. Directed checks follow the plan.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int unsigned WORDS = 32;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] instr;
      logic [15:0] ipc;
      logic [15:0] ipc4;
      logic        valid;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [15:0] redirect_target_i;
   logic [15:0] pc_o;
   logic [31:0] ifid_instr_o;
   logic [15:0] ifid_pc_o;
   logic [15:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        fetch_fault_o;

   int n_cmp = 0;
   int n_err = 0;

   exp_t exp_q[$];

   // Model state
   logic [15:0] m_pc;
   logic [31:0] m_instr;
   logic [15:0] m_ipc, m_ipc4;
   logic        m_valid, m_fault;

   fetch_stage_if imem_bus ();

   fetch_stage #(
      .RESET_PC   (16'h0000),
      .IMEM_WORDS (WORDS),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .stall_i           (stall_i),
      .redirect_i        (redirect_i),
      .redirect_target_i (redirect_target_i),
      .imem              (imem_bus),
      .pc_o              (pc_o),
      .ifid_instr_o      (ifid_instr_o),
      .ifid_pc_o         (ifid_pc_o),
      .ifid_pc4_o        (ifid_pc4_o),
      .ifid_valid_o      (ifid_valid_o),
      .fetch_fault_o     (fetch_fault_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (32'(a) < WORDS) return 32'hA000_0000 + 32'(a);
      return 32'hDEAD_BEEF;
   endfunction

   // Instruction memory: word k holds 0xA0000000+k, garbage beyond the end.
   always_comb imem_bus.imem_instr_i = mem_word(imem_bus.imem_addr_o);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_edge();
      if (reset) begin
         m_pc = 16'h0000; m_instr = NOP; m_ipc = '0; m_ipc4 = '0;
         m_valid = 1'b0; m_fault = 1'b0;
      end else if (m_fault) begin
         m_instr = NOP; m_valid = 1'b0;
      end else if (redirect_i) begin
         m_pc = {redirect_target_i[15:2], 2'b00};
         m_instr = NOP; m_valid = 1'b0;
      end else if (stall_i) begin
         m_pc = m_pc;
      end else if (32'(m_pc[15:2]) >= WORDS) begin
         m_fault = 1'b1; m_instr = NOP; m_valid = 1'b0;
      end else begin
         m_instr = mem_word({2'b00, m_pc[15:2]});
         m_ipc   = m_pc;
         m_ipc4  = m_pc + 16'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 16'd4;
      end
   endtask

   // Drive one cycle of stimulus, queue the prediction, compare after the edge.
   task automatic step(input logic rst, input logic st, input logic rd, input logic [15:0] tgt);
      exp_t e;
      reset = rst; stall_i = st; redirect_i = rd; redirect_target_i = tgt;
      model_edge();
      exp_q.push_back({m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_fault});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("sb_pc",    32'(pc_o),                    32'(e.pc));
      check("sb_addr",  32'(imem_bus.imem_addr_o),    32'(e.pc[15:2]));
      check("sb_instr", ifid_instr_o,                 e.instr);
      check("sb_valid", 32'(ifid_valid_o),            32'(e.valid));
      check("sb_fault", 32'(fetch_fault_o),           32'(e.fault));
      check("sb_ipc",   32'(ifid_pc_o),               32'(e.ipc));
      check("sb_ipc4",  32'(ifid_pc4_o),              32'(e.ipc4));
      if (ifid_valid_o)
         check("pc4_rel", 32'(ifid_pc4_o), 32'(ifid_pc_o + 16'd4));
      check("pc_align", 32'(pc_o[1:0]), 32'd0);
   endtask

   initial begin
      m_pc = '0; m_instr = NOP; m_ipc = '0; m_ipc4 = '0; m_valid = 1'b0; m_fault = 1'b0;
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
      #2;

      // Reset for two cycles
      step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("rst_pc",    32'(pc_o), 32'h0);
      check("rst_addr",  32'(imem_bus.imem_addr_o), 32'h0);
      check("rst_valid", 32'(ifid_valid_o), 32'h0);
      check("rst_instr", ifid_instr_o, 32'h0000_0013);
      check("rst_fault", 32'(fetch_fault_o), 32'h0);

      // Two fetches bring pc to 0x0008, then stall for two cycles
      step(1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("stall_pc",    32'(pc_o), 32'h0008);
      check("stall_ipc",   32'(ifid_pc_o), 32'h0004);
      check("stall_instr", ifid_instr_o, 32'hA000_0001);
      check("stall_addr",  32'(imem_bus.imem_addr_o), 32'h2);

      // Release: third instruction lands in IF/ID
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("seq_instr", ifid_instr_o, 32'hA000_0002);
      check("seq_ipc",   32'(ifid_pc_o), 32'h0008);
      check("seq_ipc4",  32'(ifid_pc4_o), 32'h000C);
      check("seq_pc",    32'(pc_o), 32'h000C);
      check("seq_valid", 32'(ifid_valid_o), 32'h1);

      // Misaligned redirect together with stall: redirect wins
      step(1'b0, 1'b1, 1'b1, 16'h002B);
      check("rd_pc",    32'(pc_o), 32'h0028);
      check("rd_valid", 32'(ifid_valid_o), 32'h0);
      check("rd_ipc",   32'(ifid_pc_o), 32'h0008);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("rd_instr", ifid_instr_o, 32'hA000_000A);
      check("rd_ipc2",  32'(ifid_pc_o), 32'h0028);

      // Fetch the last word, then run off the end
      step(1'b0, 1'b0, 1'b1, 16'h007C);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("last_instr", ifid_instr_o, 32'hA000_001F);
      check("last_valid", 32'(ifid_valid_o), 32'h1);
      check("last_pc",    32'(pc_o), 32'h0080);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("oob_fault", 32'(fetch_fault_o), 32'h1);
      check("oob_valid", 32'(ifid_valid_o), 32'h0);
      check("oob_pc",    32'(pc_o), 32'h0080);
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      check("halt_pc",    32'(pc_o), 32'h0080);
      check("halt_fault", 32'(fetch_fault_o), 32'h1);

      // Reset out of the fault, then resume
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("rec_fault", 32'(fetch_fault_o), 32'h0);
      check("rec_pc",    32'(pc_o), 32'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("rec_instr", ifid_instr_o, 32'hA000_0000);
      check("rec_valid", 32'(ifid_valid_o), 32'h1);

      // Random mix against the model
      for (int i = 0; i < 300; i++) begin
         logic r, s, d;
         logic [15:0] t;
         r = ($urandom_range(0, 39) == 0);
         s = ($urandom_range(0, 3) == 0);
         d = ($urandom_range(0, 7) == 0);
         t = 16'($urandom_range(0, 16'h0090));
         step(r, s, d, t);
      end

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
